// File: rtl/spec_dev_pkg.sv
// Shared types and constants for the spec_dig_dev self-test driver.
//   state_e      : driver sequencer states
//   D_W          : default operand/result width
//   DEBOUNCE_MIN : device debounce window plus synchroniser depth, in clk;
//                  the settle time must be longer than this on real hardware
//   A_THRESH     : operand A value above which the device takes its second branch
package spec_dev_pkg;
  localparam int D_W          = 4;
  localparam int DEBOUNCE_MIN = 2**10 + 2;
  localparam int A_THRESH     = 9;

  typedef enum logic [2:0] {IDLE, APPLY, RELEASE, WAIT, CHECK, NEXT} state_e;
endpackage

// File: rtl/spec_dev_driver_if.sv
// Bus between the driver (master) and the spec_dig_dev device (slave).
//   d1, d2        : operands, bit 0 is the MSB
//   dev_reset     : device reset, active high
//   dev_div_reset : divider reset, driver holds it low
//   dev_result    : device S1, bit 0 is the MSB
//   dev_ready     : device result-ready
interface spec_dev_driver_if #(parameter int D_W = spec_dev_pkg::D_W);
  logic [0:D_W-1] d1;
  logic [0:D_W-1] d2;
  logic           dev_reset;
  logic           dev_div_reset;
  logic [0:D_W-1] dev_result;
  logic           dev_ready;

  modport master (output d1, d2, dev_reset, dev_div_reset,
                  input  dev_result, dev_ready);
  modport slave  (input  d1, d2, dev_reset, dev_div_reset,
                  output dev_result, dev_ready);
endinterface

// File: rtl/spec_dev_golden.sv
// Combinational reference of the device algorithm, all arithmetic mod 2**D_W.
//   A, B : operands (bit 0 = MSB)
//   R    : expected S1 (bit 0 = MSB)
module spec_dev_golden #(
  parameter int D_W = spec_dev_pkg::D_W
) (
  input  logic [0:D_W-1] A,
  input  logic [0:D_W-1] B,
  output logic [0:D_W-1] R
);
  import spec_dev_pkg::*;

  // Work in conventional [D_W-1:0] order; assignment keeps MSB aligned.
  // Every intermediate is D_W wide so each step truncates mod 2**D_W
  // (the A>9 branch shifts the already-wrapped sum).
  logic [D_W-1:0] a, b, x, s2, s3, t, sum;

  always_comb begin
    a   = A;
    b   = B;
    x   = a ^ b;
    s2  = a << 2;
    s3  = (x << 3) + x + s2 + (b >> 3);
    t   = a + (b << 2) + b;
    sum = a + b;
    if (int'(a) <= A_THRESH) R = ~t ^ s3;
    else                     R = (sum >> 3) + (~((b << 1) & s2) | x);
  end
endmodule

// File: rtl/spec_dev_driver.sv
// Self-test sequencer for spec_dig_dev: sweeps {d1,d2} from VEC_FIRST to
// VEC_LAST, holds each pair with the device in reset, releases reset, waits
// for the ready rising edge, and checks S1 against spec_dev_golden.
//   clk, reset   : clock, async active-low reset
//   start        : one-clk pulse, accepted only in IDLE
//   dev          : device bus (master side)
//   busy, done   : sweep running / finished (done sticky until next start)
//   pass         : valid with done; no mismatches and no timeouts
//   err_count    : saturating mismatch count
//   timeout_flag : sticky, some vector never produced ready
//   fail_vec     : {d1,d2} of the first mismatch or timeout
module spec_dev_driver #(
  parameter int          D_W            = spec_dev_pkg::D_W,
  parameter int          SETTLE_CYCLES  = 2048,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000_000,
  parameter int          VEC_FIRST      = 0,
  parameter int          VEC_LAST       = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  spec_dev_driver_if.master  dev,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [15:0]        err_count,
  output logic               timeout_flag,
  output logic [2*D_W-1:0]   fail_vec
);
  import spec_dev_pkg::*;

  localparam int          VW          = 2*D_W;
  localparam logic [VW-1:0] VF        = VW'(VEC_FIRST);
  localparam logic [VW-1:0] VL        = VW'(VEC_LAST);
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] TMO_LAST    = TIMEOUT_CYCLES - 32'd1;

  state_e          state_q, state_d;
  logic [VW-1:0]   vec_q, vec_d;
  logic [31:0]     cnt_q, cnt_d;       // settle counter in APPLY, timeout counter in WAIT
  logic            ready_q, ready_d;
  logic [0:D_W-1]  res_q, res_d;
  logic            dev_reset_q, dev_reset_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [15:0]     err_q, err_d;
  logic            tmo_q, tmo_d;
  logic [VW-1:0]   fail_q, fail_d;

  logic [0:D_W-1]  op_a, op_b, gold_r;
  logic            rdy_rise, first_fail;

  // Operands come straight from the vector register, so they only move on
  // the NEXT->APPLY edge, the same edge that raises dev_reset.
  assign op_a              = vec_q[VW-1:D_W];
  assign op_b              = vec_q[D_W-1:0];
  assign dev.d1            = op_a;
  assign dev.d2            = op_b;
  assign dev.dev_reset     = dev_reset_q;
  assign dev.dev_div_reset = 1'b0;

  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign err_count    = err_q;
  assign timeout_flag = tmo_q;
  assign fail_vec     = fail_q;

  spec_dev_golden #(.D_W(D_W)) u_golden (.A(op_a), .B(op_b), .R(gold_r));

  assign rdy_rise   = dev.dev_ready & ~ready_q;
  // err_count saturates but never returns to zero, so this stays false after the first failure.
  assign first_fail = (err_q == 16'd0) && !tmo_q;

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    cnt_d       = cnt_q;
    ready_d     = dev.dev_ready;
    res_d       = res_q;
    dev_reset_d = dev_reset_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_d       = err_q;
    tmo_d       = tmo_q;
    fail_d      = fail_q;
    case (state_q)
      IDLE: if (start) begin
        vec_d       = VF;
        err_d       = 16'd0;
        tmo_d       = 1'b0;
        fail_d      = '0;
        done_d      = 1'b0;
        busy_d      = 1'b1;
        cnt_d       = 32'd0;
        dev_reset_d = 1'b1;
        state_d     = APPLY;
      end
      APPLY: begin
        dev_reset_d = 1'b1;
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = 32'd0;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      RELEASE: begin
        dev_reset_d = 1'b0;
        cnt_d       = 32'd0;
        state_d     = WAIT;
      end
      WAIT: begin
        if (rdy_rise) begin
          res_d   = dev.dev_result;
          state_d = CHECK;
        end else if (cnt_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          if (first_fail) fail_d = vec_q;
          state_d = NEXT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      CHECK: begin
        if (res_q != gold_r) begin
          if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          if (first_fail) fail_d = vec_q;
        end
        state_d = NEXT;
      end
      NEXT: begin
        dev_reset_d = 1'b1;
        cnt_d       = 32'd0;
        if (vec_q == VL) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_q == 16'd0) && !tmo_q;
          state_d = IDLE;
        end else begin
          vec_d   = vec_q + VW'(1);
          state_d = APPLY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      vec_q       <= '0;
      cnt_q       <= 32'd0;
      ready_q     <= 1'b0;
      res_q       <= '0;
      dev_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= 16'd0;
      tmo_q       <= 1'b0;
      fail_q      <= '0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      res_q       <= res_d;
      dev_reset_q <= dev_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
      fail_q      <= fail_d;
    end
  end
endmodule

// File: tb/tb_spec_dev_driver.sv
// Directed bench for spec_dev_driver: a full-range instance with short
// settle/timeout and a single-vector instance, each driven by a small
// behavioural device model built on an independent reference function.
module tb_spec_dev_driver;
  localparam int D_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic start1 = 1'b0;
  always #5 clk = ~clk;

  spec_dev_driver_if #(.D_W(D_W)) dif ();
  spec_dev_driver_if #(.D_W(D_W)) oif ();

  logic        busy, done, pass, tflag;
  logic [15:0] errc;
  logic [7:0]  fvec;
  logic        o_busy, o_done, o_pass, o_tflag;
  logic [15:0] o_errc;
  logic [7:0]  o_fvec;

  spec_dev_driver #(.D_W(D_W), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(32'd100),
                    .VEC_FIRST(0), .VEC_LAST(255)) u_dut (
    .clk(clk), .reset(reset), .start(start), .dev(dif),
    .busy(busy), .done(done), .pass(pass), .err_count(errc),
    .timeout_flag(tflag), .fail_vec(fvec));

  spec_dev_driver #(.D_W(D_W), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(32'd100),
                    .VEC_FIRST(8'h35), .VEC_LAST(8'h35)) u_one (
    .clk(clk), .reset(reset), .start(start1), .dev(oif),
    .busy(o_busy), .done(o_done), .pass(o_pass), .err_count(o_errc),
    .timeout_flag(o_tflag), .fail_vec(o_fvec));

  logic [0:D_W-1] ga, gb, gr;
  spec_dev_golden #(.D_W(D_W)) u_gold (.A(ga), .B(gb), .R(gr));

  int tests = 0;
  int fails = 0;

  // Independent integer formulation of the device algorithm.
  function automatic logic [3:0] ref_r(input int a, input int b);
    int x, s2, s3, t, r;
    x  = a ^ b;
    s2 = (a * 4) & 15;
    if (a <= 9) begin
      s3 = (x * 8 + x + s2 + b / 8) & 15;
      t  = (a + b * 5) & 15;
      r  = (~t) ^ s3;
    end else begin
      r = ((a + b) & 15) / 8 + ((~((b * 2) & s2)) | x);
    end
    return 4'(r & 15);
  endfunction

  // Device models: ready rises a few clk after reset release.
  // mode 0 correct, 1 corrupts vector C5 (returns 14), 2 never ready.
  int mode = 0;
  int dly = 0;
  always @(posedge clk) begin
    if (dif.dev_reset) begin
      dif.dev_ready <= 1'b0;
      dly <= 0;
    end else if (mode != 2 && dly == 3) begin
      dif.dev_ready  <= 1'b1;
      dif.dev_result <= (mode == 1 && {dif.d1, dif.d2} == 8'hC5) ? 4'd14
                        : ref_r(int'(dif.d1), int'(dif.d2));
    end else begin
      dly <= dly + 1;
    end
  end

  int odly = 0;
  always @(posedge clk) begin
    if (oif.dev_reset) begin
      oif.dev_ready <= 1'b0;
      odly <= 0;
    end else if (odly == 3) begin
      oif.dev_ready  <= 1'b1;
      oif.dev_result <= ref_r(int'(oif.d1), int'(oif.d2));
    end else begin
      odly <= odly + 1;
    end
  end

  // Monitor on u_dut: counts dev_reset falls, checks operand order at each
  // release, and measures the length of each dev_reset-low window.
  bit         clr = 1'b1;
  logic       prev_rst = 1'b1;
  int         falls = 0;
  int         seq_err = 0;
  int         run = 0;
  int         last_low = 0;
  logic [7:0] exp_v = 8'h00;
  always @(negedge clk) begin
    prev_rst <= dif.dev_reset;
    if (clr) begin
      falls   <= 0;
      seq_err <= 0;
      exp_v   <= 8'h00;
      run     <= 0;
    end else begin
      if (prev_rst && !dif.dev_reset) begin
        falls <= falls + 1;
        exp_v <= exp_v + 8'd1;
        if ({dif.d1, dif.d2} !== exp_v) seq_err <= seq_err + 1;
      end
      if (!dif.dev_reset) run <= run + 1;
      else if (run != 0) begin
        last_low <= run;
        run      <= 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    clr = 1'b1;
    @(posedge clk);
    @(posedge clk);
    clr = 1'b0;
  endtask

  task automatic pulse(input bit which);
    @(negedge clk);
    if (which) start1 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit which, input string tag);
    int n = 0;
    while (!(which ? o_done : done) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(which ? o_done : done), 32'd1);
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_d1d2",      32'({dif.d1, dif.d2}), 32'h0);
    chk("rst_dev_reset", 32'(dif.dev_reset), 32'd1);
    chk("rst_div_reset", 32'(dif.dev_div_reset), 32'd0);
    chk("rst_busy",      32'(busy), 32'd0);
    chk("rst_done",      32'(done), 32'd0);
    chk("rst_pass",      32'(pass), 32'd0);
    chk("rst_err",       32'(errc), 32'd0);
    chk("rst_tflag",     32'(tflag), 32'd0);
    chk("rst_fvec",      32'(fvec), 32'd0);
    reset = 1'b1;

    // Golden sub-module, hand-computed vectors incl. the A=9/A=10 boundary
    ga = 4'd3;  gb = 4'd5;  #1 chk("gold_35", 32'(gr), 32'd1);
    ga = 4'd12; gb = 4'd5;  #1 chk("gold_C5", 32'(gr), 32'd15);
    ga = 4'd0;  gb = 4'd0;  #1 chk("gold_00", 32'(gr), 32'd15);
    ga = 4'd9;  gb = 4'd15; #1 chk("gold_9F", 32'(gr), 32'd0);
    ga = 4'd10; gb = 4'd0;  #1 chk("gold_A0", 32'(gr), 32'd0);

    // Single vector 35
    pulse(1'b1);
    wait_done(200, 1'b1, "one_done");
    chk("one_pass", 32'(o_pass), 32'd1);
    chk("one_err",  32'(o_errc), 32'd0);
    chk("one_fvec", 32'(o_fvec), 32'd0);
    chk("one_ops",  32'({oif.d1, oif.d2}), 32'h35);
    chk("one_busy", 32'(o_busy), 32'd0);

    // Full sweep, correct device
    mode = 0;
    clear_mon();
    pulse(1'b0);
    chk("full_busy", 32'(busy), 32'd1);
    wait_done(6000, 1'b0, "full_done");
    chk("full_pass",  32'(pass), 32'd1);
    chk("full_err",   32'(errc), 32'd0);
    chk("full_tflag", 32'(tflag), 32'd0);
    chk("full_falls", 32'(falls), 32'd256);
    chk("full_seq",   32'(seq_err), 32'd0);
    chk("full_last",  32'({dif.d1, dif.d2}), 32'hFF);

    // C5 corrupted, with a stray start during APPLY of vector 0
    mode = 1;
    clear_mon();
    pulse(1'b0);
    @(negedge clk);
    pulse(1'b0);
    wait_done(6000, 1'b0, "c5_done");
    chk("c5_err",   32'(errc), 32'd1);
    chk("c5_fvec",  32'(fvec), 32'hC5);
    chk("c5_pass",  32'(pass), 32'd0);
    chk("c5_tflag", 32'(tflag), 32'd0);
    chk("c5_falls", 32'(falls), 32'd256);
    chk("c5_seq",   32'(seq_err), 32'd0);

    // Device never ready: every vector times out, sweep still completes
    mode = 2;
    clear_mon();
    pulse(1'b0);
    wait_done(30000, 1'b0, "tmo_done");
    chk("tmo_flag",  32'(tflag), 32'd1);
    chk("tmo_pass",  32'(pass), 32'd0);
    chk("tmo_err",   32'(errc), 32'd0);
    chk("tmo_fvec",  32'(fvec), 32'h00);
    chk("tmo_falls", 32'(falls), 32'd256);
    chk("tmo_low",   32'(last_low), 32'd101);  // 100 clk WAIT + 1 clk NEXT

    // Reset during WAIT of vector 3, then restart from VEC_FIRST
    mode = 0;
    clear_mon();
    pulse(1'b0);
    for (int n = 0; n < 500 && falls < 4; n++) @(posedge clk);
    chk("rw_reach", 32'(falls), 32'd4);
    #2 reset = 1'b0;
    #1;
    chk("rw_busy",      32'(busy), 32'd0);
    chk("rw_dev_reset", 32'(dif.dev_reset), 32'd1);
    chk("rw_d1d2",      32'({dif.d1, dif.d2}), 32'h0);
    chk("rw_done",      32'(done), 32'd0);
    chk("rw_pass",      32'(pass), 32'd0);
    repeat (2) @(posedge clk);
    reset = 1'b1;
    clear_mon();
    pulse(1'b0);
    wait_done(6000, 1'b0, "rs_done");
    chk("rs_falls", 32'(falls), 32'd256);
    chk("rs_seq",   32'(seq_err), 32'd0);
    chk("rs_pass",  32'(pass), 32'd1);
    chk("rs_err",   32'(errc), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spec_dev_driver.md
Name: spec_dev_driver

Overview:
- Operand sequencer and checker on the initiator side of the spec_dig_dev interface.
- Drives the device operand buses d1/d2 and its reset, then waits for the device `ready` pulse and captures `S1`.
- Compares the captured result against an internal golden model of the device algorithm and accumulates pass/fail status.
- Used for on-board self-test: it sweeps every operand pair, or a sub-range of pairs, automatically after `start`.

Parameters:
- D_W, 4: operand/result width. Bit index 0 is the MSB on all operand and result buses.
- SETTLE_CYCLES, 2048: clk cycles that operands are held stable with the device in reset. Must exceed the device debounce window of 2**10 clk plus 2 synchroniser clk.
- TIMEOUT_CYCLES, 32'd1_000_000_000: maximum clk cycles to wait for `dev_ready` after reset release.
- VEC_FIRST, 0: first 2*D_W-bit vector index {d1,d2}.
- VEC_LAST, 255: last vector index, inclusive.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-clk pulse; starts a sweep when idle, ignored while busy
- d1  out  [0:D_W-1]  operand A to the device
- d2  out  [0:D_W-1]  operand B to the device
- dev_reset  out  1  device reset, active high (drives reset_spec_dev_extern)
- dev_div_reset  out  1  divider reset to the device; held 0
- dev_result  in  [0:D_W-1]  device S1
- dev_ready  in  1  device ready
- busy  out  1  sweep in progress
- done  out  1  sweep finished; sticky until the next `start`
- pass  out  1  valid when `done`; 1 if err_count==0 and no timeout
- err_count  out  16  mismatch count
- timeout_flag  out  1  sticky; set if any vector timed out
- fail_vec  out  2*D_W  {d1,d2} of the first mismatch or timeout

Behaviour:
- Reset values: d1=d2=0, dev_reset=1, dev_div_reset=0, busy=0, done=0, pass=0, err_count=0, timeout_flag=0, fail_vec=0, state=IDLE. Any reset mid-sweep aborts to IDLE with these values.
- IDLE: on `start`:
  - vec<=VEC_FIRST; clear err_count, timeout_flag, fail_vec, done.
  - busy<=1; go to APPLY.
- APPLY:
  - d1=vec[2D_W-1:D_W], d2=vec[D_W-1:0]; dev_reset=1; counter runs 0..SETTLE_CYCLES-1.
  - Then go to RELEASE.
- RELEASE:
  - dev_reset<=0; sample ready_q<=dev_ready; clear the timeout counter.
  - Next cycle go to WAIT.
- WAIT:
  - Detect a dev_ready rising edge (dev_ready & ~ready_q); register dev_ready every cycle.
  - On the edge: capture dev_result the same cycle and go to CHECK.
  - If the counter reaches TIMEOUT_CYCLES-1 first: set timeout_flag; load fail_vec if this is the first failure; go to NEXT.
- CHECK:
  - If captured != golden(d1,d2): err_count saturating +1 (stops at 16'hFFFF); load fail_vec if this is the first failure.
  - Go to NEXT.
- NEXT:
  - dev_reset<=1.
  - If vec==VEC_LAST: busy<=0, done<=1, pass<=(err_count==0 && !timeout_flag), go to IDLE.
  - Otherwise vec<=vec+1 and go to APPLY.
  - No wrap-around past VEC_LAST. VEC_FIRST==VEC_LAST runs exactly one vector.
- Operands are stable from APPLY entry until leaving NEXT. d1/d2 never change while dev_reset=0.
- A `start` pulse while busy is ignored. `start` in the same cycle that done is set is also ignored.
- Golden model, all arithmetic mod 2**D_W, ~ is bitwise:
  - Always: x=A^B, S2=(A<<2).
  - A<=9: S3=(x<<3)+x+S2+(B>>3); R=~(A+(B<<2)+B)^S3.
  - A>9: R=((A+B)>>3) + ((~((B<<1)&S2)) | x).

Decomposition:
- Package spec_dev_pkg holds:
  - the state enum {IDLE, APPLY, RELEASE, WAIT, CHECK, NEXT};
  - the D_W localparam;
  - the DEBOUNCE_MIN constant (2**10+2);
  - the branch threshold constant 9.
- One sub-module: spec_dev_golden, purely combinational, inputs A and B, output R. It is shared with testbench scoreboards.

Test Plan:
- Single vector VEC_FIRST=VEC_LAST=8'h35 (A=3, B=5), behavioural DUT model returns 1 -> done=1, pass=1, err_count=0.
- Vector 8'hC5 (A=12, B=5) -> golden R=15. DUT model returns 14 -> err_count=1, fail_vec=8'hC5, pass=0.
- Vector 8'h00 -> golden R=15. Full 0..255 sweep against a correct DUT model -> err_count=0, pass=1, and 256 dev_reset high→low transitions.
- DUT model never raises ready, TIMEOUT_CYCLES=100 -> timeout_flag=1 after 100 clk in WAIT, sweep continues, pass=0.
- reset driven low during WAIT of vector 3 -> outputs return to reset values asynchronously; a new `start` restarts from VEC_FIRST.
- `start` pulsed during APPLY -> ignored; vec sequence and counters are unchanged.
